// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      OP_MUL    = 3'b000,
      OP_MULH   = 3'b001,
      OP_MULHSU = 3'b010,
      OP_MULHU  = 3'b011,
      OP_DIV    = 3'b100,
      OP_DIVU   = 3'b101,
      OP_REM    = 3'b110,
      OP_REMU   = 3'b111
   } muldiv_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_e;

   localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN   = 32'h8000_0000;

endpackage

// File: rtl/muldiv_operand_prep.sv
// Operand sign/magnitude extraction and divide special-case detection,
// evaluated on the request bus at accept time.
module muldiv_operand_prep
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       funct3,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             sign_a,
   output logic             sign_b,
   output logic [WIDTH-1:0] mag_a,
   output logic [WIDTH-1:0] mag_b,
   output logic             special,
   output logic [WIDTH-1:0] special_result
);

   muldiv_op_e op;
   logic       signed_a;
   logic       signed_b;
   logic       is_div;
   logic       div_zero;
   logic       div_ovf;

   always_comb begin
      op       = muldiv_op_e'(funct3);
      signed_a = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
      signed_b = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
      is_div   = funct3[2];

      sign_a = signed_a & operand_a[WIDTH-1];
      sign_b = signed_b & operand_b[WIDTH-1];
      // INT_MIN negates to itself, which is still the correct unsigned magnitude
      mag_a  = sign_a ? (~operand_a + 1'b1) : operand_a;
      mag_b  = sign_b ? (~operand_b + 1'b1) : operand_b;

      div_zero = is_div && (operand_b == '0);
      div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                 (operand_a == INT_MIN) && (operand_b == DIV0_QUOT);
      special  = div_zero | div_ovf;

      special_result = '0;
      if (div_zero) begin
         special_result = funct3[1] ? operand_a : DIV0_QUOT;
      end else if (div_ovf) begin
         special_result = funct3[1] ? '0 : INT_MIN;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M unit: radix-2 shift-add multiply / restoring divide on
// magnitudes, followed by a one-cycle sign fix.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | one radix-2 iteration per cycle, 32 cycles
// FIX   | sign correction and half select into o_result
// DONE  | o_valid held until i_ready
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_funct3,
   input  logic [WIDTH-1:0] i_operand_a,
   input  logic [WIDTH-1:0] i_operand_b,
   input  logic             i_flush,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   muldiv_state_e      state, state_next;
   logic [CNT_W-1:0]   count;
   muldiv_op_e         op;
   logic               sign_a_q, sign_b_q;
   logic [WIDTH-1:0]   mag_b_q;
   logic [2*WIDTH-1:0] work;
   logic [WIDTH-1:0]   result;

   logic               prep_sign_a, prep_sign_b, prep_special;
   logic [WIDTH-1:0]   prep_mag_a, prep_mag_b, prep_special_result;
   logic               accept;

   muldiv_operand_prep #(.WIDTH(WIDTH)) u_prep (
      .funct3         (i_funct3),
      .operand_a      (i_operand_a),
      .operand_b      (i_operand_b),
      .sign_a         (prep_sign_a),
      .sign_b         (prep_sign_b),
      .mag_a          (prep_mag_a),
      .mag_b          (prep_mag_b),
      .special        (prep_special),
      .special_result (prep_special_result)
   );

   assign accept = i_valid && o_ready && !i_flush;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= ST_IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      o_ready    = (state == ST_IDLE);
      o_valid    = (state == ST_DONE);
      case (state)
         ST_IDLE: if (accept) state_next = prep_special ? ST_DONE : ST_CALC;
         ST_CALC: if (count == CNT_W'(WIDTH-1)) state_next = ST_FIX;
         ST_FIX:  state_next = ST_DONE;
         ST_DONE: if (i_ready) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
      if (i_flush) state_next = ST_IDLE;
   end

   // Iteration datapath
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] div_next;

   always_comb begin
      mul_sum  = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, mag_b_q} : '0);
      mul_next = {mul_sum, work[WIDTH-1:1]};

      div_shift = work[2*WIDTH-1:WIDTH-1];
      div_diff  = div_shift - {1'b0, mag_b_q};
      // a set MSB in the shifted remainder already exceeds any 32-bit divisor
      div_ge    = div_shift[WIDTH] | ~div_diff[WIDTH];
      div_next  = div_ge ? {div_diff[WIDTH-1:0], work[WIDTH-2:0], 1'b1}
                         : {div_shift[WIDTH-1:0], work[WIDTH-2:0], 1'b0};
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix, fix_result;

   always_comb begin
      prod_fix = (sign_a_q ^ sign_b_q) ? (~work + 1'b1) : work;
      quot_fix = (sign_a_q ^ sign_b_q) ? (~work[WIDTH-1:0] + 1'b1) : work[WIDTH-1:0];
      rem_fix  = sign_a_q ? (~work[2*WIDTH-1:WIDTH] + 1'b1) : work[2*WIDTH-1:WIDTH];
      case (op)
         OP_MUL:                      fix_result = prod_fix[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:             fix_result = quot_fix;
         default:                     fix_result = rem_fix;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         count    <= '0;
         op       <= OP_MUL;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         mag_b_q  <= '0;
         work     <= '0;
         result   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op       <= muldiv_op_e'(i_funct3);
               sign_a_q <= prep_sign_a;
               sign_b_q <= prep_sign_b;
               mag_b_q  <= prep_mag_b;
               count    <= '0;
               // both engines start with |a| in the low half and zero above
               work     <= {{WIDTH{1'b0}}, prep_mag_a};
               if (prep_special) result <= prep_special_result;
            end
            ST_CALC: begin
               count <= count + 1'b1;
               work  <= op[2] ? div_next : mul_next;
            end
            ST_FIX:  result <= fix_result;
            default: ;
         endcase
      end
   end

   assign o_result = result;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed expectations.
module tb_muldiv_sequencer;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [2:0]  i_funct3 = 3'd0;
   logic [31:0] i_operand_a = '0;
   logic [31:0] i_operand_b = '0;
   logic        i_flush = 1'b0;
   logic        o_valid;
   logic        i_ready = 1'b0;
   logic [31:0] o_result;

   int n_vec = 0;
   int n_err = 0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_funct3    (i_funct3),
      .i_operand_a (i_operand_a),
      .i_operand_b (i_operand_b),
      .i_flush     (i_flush),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Present one request, scramble the bus after accept, wait for o_valid.
   task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_funct3    = f;
      i_operand_a = a;
      i_operand_b = b;
      i_valid     = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid     = 1'b0;
      i_funct3    = 3'($urandom);
      i_operand_a = $urandom;
      i_operand_b = $urandom;
   endtask

   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input int exp_lat, input bit release_it);
      int lat;
      start_op(f, a, b);
      lat = 1;
      while (!o_valid && lat < 100) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, o_result, exp_res);
      if (release_it) begin
         i_ready = 1'b1;
         @(posedge i_clk);
         #1;
         i_ready = 1'b0;
      end
   endtask

   typedef struct {
      string       tag;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] held;
      bit          stable;
      bit          seen;

      vecs.push_back('{"mul",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
      vecs.push_back('{"mul_wrap", 3'b000, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 34});
      vecs.push_back('{"mulh",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34});
      vecs.push_back('{"mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
      vecs.push_back('{"div",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 34});
      vecs.push_back('{"rem",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"div_nb",   3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34});
      vecs.push_back('{"rem_nb",   3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 34});
      vecs.push_back('{"divu",     3'b101, 32'd100,       32'd7,         32'd14,        34});
      vecs.push_back('{"remu",     3'b111, 32'd100,       32'd7,         32'd2,         34});
      vecs.push_back('{"divu_big", 3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 34});
      vecs.push_back('{"divu_0",   3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{"remu_0",   3'b111, 32'd5,         32'd0,         32'd5,         1});
      vecs.push_back('{"div_0",    3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{"rem_0",    3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1});
      vecs.push_back('{"div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{"rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1});

      #12;
      chk("rst_ready",  32'(o_ready),  32'd1);
      chk("rst_valid",  32'(o_valid),  32'd0);
      chk("rst_result", o_result,      32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      foreach (vecs[i])
         run_op(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat, 1'b1);

      // backpressure in DONE
      run_op("bp", 3'b101, 32'd100, 32'd7, 32'd14, 34, 1'b0);
      held   = o_result;
      stable = 1'b1;
      repeat (10) begin
         @(posedge i_clk);
         #1;
         if (!o_valid || o_result !== held || o_ready) stable = 1'b0;
      end
      chk("bp_stable", 32'(stable), 32'd1);
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      i_ready = 1'b0;
      chk("bp_ready_after", 32'(o_ready), 32'd1);
      chk("bp_valid_after", 32'(o_valid), 32'd0);
      run_op("bp_next", 3'b111, 32'd100, 32'd7, 32'd2, 34, 1'b1);

      // flush at count=15 of a DIV
      start_op(3'b100, 32'hFFFF_FFF9, 32'd2);
      repeat (15) @(posedge i_clk);
      #1;
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("flush_calc_ready", 32'(o_ready), 32'd1);
      chk("flush_calc_valid", 32'(o_valid), 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(posedge i_clk);
         #1;
         seen |= o_valid;
      end
      chk("flush_calc_no_valid", 32'(seen), 32'd0);

      // flush in DONE with i_ready low
      run_op("fd", 3'b000, 32'd3, 32'd5, 32'd15, 34, 1'b0);
      i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_flush = 1'b0;
      chk("flush_done_valid", 32'(o_valid), 32'd0);
      chk("flush_done_ready", 32'(o_ready), 32'd1);

      // request presented together with flush is dropped
      @(negedge i_clk);
      i_funct3 = 3'b101; i_operand_a = 32'd9; i_operand_b = 32'd0;
      i_valid = 1'b1; i_flush = 1'b1;
      @(posedge i_clk);
      #1;
      i_valid = 1'b0; i_flush = 1'b0;
      chk("drop_ready", 32'(o_ready), 32'd1);
      chk("drop_valid", 32'(o_valid), 32'd0);

      // async reset mid-CALC; o_result holds 15 from the previous op
      start_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      repeat (10) @(posedge i_clk);
      #1;
      i_rst_n = 1'b0;
      #1;
      chk("arst_ready",  32'(o_ready), 32'd1);
      chk("arst_valid",  32'(o_valid), 32'd0);
      chk("arst_result", o_result,     32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run_op("post_rst", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M unit beside the single-cycle ALU. Executes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU.
- Iterative radix-2 engine: shift-add for multiply, restoring division for divide. Runs on operand magnitudes, then applies a sign fix.
- Ready/valid handshake on both sides, so the core stalls while the unit is busy.
- Shares the operand buses feeding the ALU; its result is muxed into the writeback path next to o_alu_data.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is verified.
- CNT_W, $clog2(WIDTH)+1, iteration counter width. Derived; do not override.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept a request (high only in IDLE).
- i_funct3  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- i_operand_a  in  WIDTH  rs1 value.
- i_operand_b  in  WIDTH  rs2 value.
- i_flush  in  1  abandon any in-flight operation.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts the result.
- o_result  out  WIDTH  result, held stable while o_valid=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE, o_ready=1, o_valid=0, o_result=0. All internal registers clear.
- Accept: a request is taken on an edge where i_valid && o_ready. funct3 and operands are latched at that edge; inputs are ignored afterwards.
- State IDLE:
  - On accept with a divide op and b==0, or signed DIV/REM with a==0x80000000 and b==0xFFFFFFFF: go to DONE. The special result is loaded at that same edge.
  - Otherwise on accept: go to CALC with count=0.
- State CALC: one iteration per cycle, 32 iterations. After the 32nd edge go to FIX.
  - Multiply: 64-bit {acc,mplier} register. If LSB=1, add the multiplicand magnitude into acc using a 33-bit add that keeps the carry. Then shift right by 1.
  - Divide: 64-bit {rem,quot} register. Shift left, do a 33-bit trial subtract of the divisor magnitude. If non-negative, commit it and set the quotient LSB.
- State FIX: one cycle. Two's-complement negate as needed, select the high or low half, register o_result, go to DONE.
  - Product negated when sign_a^sign_b. Signedness per op: MULH both signed, MULHSU a signed only, MULHU and MUL unsigned magnitudes, with MUL using the low half.
  - Quotient negated when sign_a^sign_b. Remainder takes the sign of the dividend.
- State DONE: o_valid=1. When i_ready=1, go to IDLE at that edge. o_ready stays 0 in DONE, so there is a one-cycle bubble before the next accept.
- Latency, counted in edges from the accept edge to o_valid high:
  - Normal op: 34 (32 CALC + 1 FIX + 1 into DONE).
  - Special case: 1.
- Special results:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=dividend (signed and unsigned).
  - Signed overflow: DIV=0x80000000, REM=0.
- Backpressure: o_result and o_valid hold indefinitely while i_ready=0.
- Flush: i_flush=1 in any state goes to IDLE at the next edge with o_valid=0 and no result.
  - Flush takes priority over accept and over i_ready.
  - A request presented with i_flush=1 is dropped.
- Arithmetic: all intermediate adds are 33-bit, so no carry or borrow is lost. Negation is ~x+1 on 64 bits for products and 32 bits for quotient and remainder.

Decomposition:
- muldiv_pkg holds:
  - funct3 enum muldiv_op_e (8 codes above);
  - state enum muldiv_state_e (IDLE, CALC, FIX, DONE);
  - constants DIV0_QUOT=32'hFFFFFFFF, INT_MIN=32'h80000000.
- One sub-module: muldiv_operand_prep (combinational). Takes funct3 and operands; outputs sign_a, sign_b, |a|, |b| and the special-case flags. It is instantiated once at accept.

Test Plan:
- MUL a=7, b=0xFFFFFFFD -> o_result=0xFFFFFFEB; o_valid high 34 edges after accept.
- MULH a=b=0x80000000 -> 0x40000000. MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0. Each special case has o_valid 1 edge after accept.
- Backpressure: hold i_ready=0 for 10 cycles in DONE -> o_valid and o_result stable. o_ready=0 until the edge after i_ready=1; the next accept is one cycle later.
- Flush at count=15 of a DIV, and again in DONE with i_ready=0 -> IDLE next edge, o_valid never asserts, o_ready=1. Async reset pulse mid-CALC -> all outputs at reset values immediately.
